up_fifo_regs: RTL and testbench

- uP-bus register slave that sits directly downstream of the Wishbone-to-uP bridge and consumes its up_rreq/up_wreq transactions.
- Provides four 32-bit registers: RX FIFO pop, TX FIFO push, status and control.
- The RX FIFO is filled from an 8-bit AXI-Stream input. The TX FIFO drains to an 8-bit AXI-Stream output.
- Intended as the generic register front end for byte-stream peripherals such as UARTs.

---
 rtl/up_fifo_regs_pkg.sv | 28 ++
 rtl/up_fifo_regs_fifo.sv | 66 ++++++
 rtl/up_fifo_regs.sv | 177 +++++++++++++++++
 tb/tb_up_fifo_regs.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_fifo_regs_pkg.sv
// Shared constants for the uP-bus FIFO register slave: register offsets,
// STATUS/CONTROL bit positions and the request/acknowledge state encoding.
package up_fifo_regs_pkg;

    localparam int RX_FIFO_REG = 'h0;
    localparam int TX_FIFO_REG = 'h4;
    localparam int STATUS_REG  = 'h8;
    localparam int CONTROL_REG = 'hC;

    localparam int STAT_RX_UNDERFLOW = 31;
    localparam int STAT_TX_OVERFLOW  = 30;
    localparam int STAT_RX_COUNT_LSB = 8;
    localparam int STAT_TX_FULL      = 3;
    localparam int STAT_TX_EMPTY     = 2;
    localparam int STAT_RX_FULL      = 1;
    localparam int STAT_RX_EMPTY     = 0;

    localparam int CTRL_RX_FLUSH  = 0;
    localparam int CTRL_TX_FLUSH  = 1;
    localparam int CTRL_TX_ENABLE = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RELEASE = 2'd2
    } xfer_state_e;

endpackage

// File: rtl/up_fifo_regs_fifo.sv
// Synchronous first-word-fall-through FIFO; head always shows the oldest entry.
// Push is refused when full, pop when empty, and flush overrides both.
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full & ~flush;
        do_pop   = pop & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/up_fifo_regs.sv
// uP-bus register slave exposing an RX FIFO (filled from AXI-Stream) and a
// TX FIFO (drained to AXI-Stream) plus STATUS and CONTROL registers.
module up_fifo_regs
    import up_fifo_regs_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 14,
    parameter int FIFO_DEPTH    = 16,
    parameter int STREAM_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     up_rreq,
    output logic                     up_rack,
    input  logic [ADDRESS_WIDTH-1:0] up_raddr,
    output logic [31:0]              up_rdata,
    input  logic                     up_wreq,
    output logic                     up_wack,
    input  logic [ADDRESS_WIDTH-1:0] up_waddr,
    input  logic [31:0]              up_wdata,
    input  logic [STREAM_WIDTH-1:0]  s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [STREAM_WIDTH-1:0]  m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    xfer_state_e       rd_state_q, rd_state_d;
    xfer_state_e       wr_state_q, wr_state_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rx_underflow_q, rx_underflow_d;
    logic              tx_overflow_q, tx_overflow_d;
    logic              tx_enable_q, tx_enable_d;
    logic              rx_flush_q, rx_flush_d;
    logic              tx_flush_q, tx_flush_d;
    logic              rstn_q;

    logic              rx_pop, tx_push, status_clr, underflow_set, overflow_set;
    logic              rx_empty, rx_full, tx_empty, tx_full;
    logic [CW-1:0]     rx_count, tx_count;
    logic [STREAM_WIDTH-1:0] rx_head, tx_head;
    logic [31:0]       status_word;
    logic              unused_bits;

    assign s_axis_tready = rstn_q & ~rx_full;
    assign m_axis_tvalid = tx_enable_q & ~tx_empty;
    assign m_axis_tdata  = tx_empty ? '0 : tx_head;
    assign up_rack       = (rd_state_q == ST_ACK);
    assign up_wack       = (wr_state_q == ST_ACK);
    assign up_rdata      = rdata_q;
    assign unused_bits   = ^{tx_count, up_wdata};

    sync_fifo_fwft #(.DEPTH(FIFO_DEPTH), .WIDTH(STREAM_WIDTH)) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (s_axis_tvalid & s_axis_tready),
        .push_data (s_axis_tdata),
        .pop       (rx_pop),
        .flush     (rx_flush_q),
        .empty     (rx_empty),
        .full      (rx_full),
        .count     (rx_count),
        .head      (rx_head)
    );

    sync_fifo_fwft #(.DEPTH(FIFO_DEPTH), .WIDTH(STREAM_WIDTH)) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (up_wdata[STREAM_WIDTH-1:0]),
        .pop       (m_axis_tvalid & m_axis_tready),
        .flush     (tx_flush_q),
        .empty     (tx_empty),
        .full      (tx_full),
        .count     (tx_count),
        .head      (tx_head)
    );

    always_comb begin
        status_word = '0;
        status_word[STAT_RX_UNDERFLOW]        = rx_underflow_q;
        status_word[STAT_TX_OVERFLOW]         = tx_overflow_q;
        status_word[STAT_RX_COUNT_LSB +: 8]   = 8'(rx_count);
        status_word[STAT_TX_FULL]             = tx_full;
        status_word[STAT_TX_EMPTY]            = tx_empty;
        status_word[STAT_RX_FULL]             = rx_full;
        status_word[STAT_RX_EMPTY]            = rx_empty;
    end

    // Read side: the action fires only on the IDLE->ACK step, so a held
    // request can never pop twice.
    always_comb begin
        rd_state_d    = rd_state_q;
        rdata_d       = rdata_q;
        rx_pop        = 1'b0;
        status_clr    = 1'b0;
        underflow_set = 1'b0;
        case (rd_state_q)
            ST_IDLE: begin
                if (up_rreq) begin
                    rd_state_d = ST_ACK;
                    rdata_d    = '0;
                    if (up_raddr == ADDRESS_WIDTH'(RX_FIFO_REG)) begin
                        if (rx_empty) begin
                            underflow_set = 1'b1;
                        end else begin
                            rx_pop  = 1'b1;
                            rdata_d = 32'(rx_head);
                        end
                    end else if (up_raddr == ADDRESS_WIDTH'(STATUS_REG)) begin
                        rdata_d    = status_word;
                        status_clr = 1'b1;
                    end else if (up_raddr == ADDRESS_WIDTH'(CONTROL_REG)) begin
                        rdata_d[CTRL_TX_ENABLE] = tx_enable_q;
                    end
                end
            end
            ST_ACK:     rd_state_d = ST_RELEASE;
            ST_RELEASE: if (!up_rreq) rd_state_d = ST_IDLE;
            default:    rd_state_d = ST_IDLE;
        endcase
        rx_underflow_d = (rx_underflow_q & ~status_clr) | underflow_set;
    end

    always_comb begin
        wr_state_d   = wr_state_q;
        tx_push      = 1'b0;
        overflow_set = 1'b0;
        tx_enable_d  = tx_enable_q;
        rx_flush_d   = 1'b0;
        tx_flush_d   = 1'b0;
        case (wr_state_q)
            ST_IDLE: begin
                if (up_wreq) begin
                    wr_state_d = ST_ACK;
                    if (up_waddr == ADDRESS_WIDTH'(TX_FIFO_REG)) begin
                        if (tx_full) overflow_set = 1'b1;
                        else         tx_push      = 1'b1;
                    end else if (up_waddr == ADDRESS_WIDTH'(CONTROL_REG)) begin
                        tx_enable_d = up_wdata[CTRL_TX_ENABLE];
                        rx_flush_d  = up_wdata[CTRL_RX_FLUSH];
                        tx_flush_d  = up_wdata[CTRL_TX_FLUSH];
                    end
                end
            end
            ST_ACK:     wr_state_d = ST_RELEASE;
            ST_RELEASE: if (!up_wreq) wr_state_d = ST_IDLE;
            default:    wr_state_d = ST_IDLE;
        endcase
        tx_overflow_d = (tx_overflow_q & ~status_clr) | overflow_set;
    end

    always_ff @(posedge clk) begin
        rstn_q <= rstn;
        if (!rstn) begin
            rd_state_q     <= ST_IDLE;
            wr_state_q     <= ST_IDLE;
            rdata_q        <= '0;
            rx_underflow_q <= 1'b0;
            tx_overflow_q  <= 1'b0;
            tx_enable_q    <= 1'b0;
            rx_flush_q     <= 1'b0;
            tx_flush_q     <= 1'b0;
        end else begin
            rd_state_q     <= rd_state_d;
            wr_state_q     <= wr_state_d;
            rdata_q        <= rdata_d;
            rx_underflow_q <= rx_underflow_d;
            tx_overflow_q  <= tx_overflow_d;
            tx_enable_q    <= tx_enable_d;
            rx_flush_q     <= rx_flush_d;
            tx_flush_q     <= tx_flush_d;
        end
    end

endmodule

// File: tb/tb_up_fifo_regs.sv
// Bench for up_fifo_regs: queue-based reference model stepped every clock,
// all outputs compared each cycle, plus directed literal checks.
module tb_up_fifo_regs;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn, up_rreq, up_wreq, s_axis_tvalid, m_axis_tready;
    logic [13:0] up_raddr, up_waddr;
    logic [31:0] up_wdata;
    logic [7:0]  s_axis_tdata;
    logic        up_rack, up_wack, s_axis_tready, m_axis_tvalid;
    logic [31:0] up_rdata;
    logic [7:0]  m_axis_tdata;

    always #5 clk = ~clk;

    up_fifo_regs #(.ADDRESS_WIDTH(14), .FIFO_DEPTH(DEPTH), .STREAM_WIDTH(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .up_rreq       (up_rreq),
        .up_rack       (up_rack),
        .up_raddr      (up_raddr),
        .up_rdata      (up_rdata),
        .up_wreq       (up_wreq),
        .up_wack       (up_wack),
        .up_waddr      (up_waddr),
        .up_wdata      (up_wdata),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    // Reference model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    bit          m_uf, m_of, m_txen, m_rxfl, m_txfl, m_rstn_q;
    bit          m_rd_ack, m_rd_rel, m_wr_ack, m_wr_rel;
    logic [31:0] m_rdata;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit rx_empty_p, rx_full_p, tx_empty_p, tx_full_p;
        bit s_push, m_pop, rx_pop, tx_push, set_uf, set_of, clr, new_rxfl, new_txfl;
        logic [31:0] status_p;
        if (!rstn) begin
            rxq.delete(); txq.delete();
            m_uf = 0; m_of = 0; m_txen = 0; m_rxfl = 0; m_txfl = 0; m_rstn_q = 0;
            m_rd_ack = 0; m_rd_rel = 0; m_wr_ack = 0; m_wr_rel = 0; m_rdata = '0;
            return;
        end
        rx_empty_p = (rxq.size() == 0);
        rx_full_p  = (rxq.size() == DEPTH);
        tx_empty_p = (txq.size() == 0);
        tx_full_p  = (txq.size() == DEPTH);
        status_p   = {m_uf, m_of, 14'd0, 8'(rxq.size()), 4'd0,
                      tx_full_p, tx_empty_p, rx_full_p, rx_empty_p};
        s_push = s_axis_tvalid && m_rstn_q && !rx_full_p;
        m_pop  = m_txen && !tx_empty_p && m_axis_tready;
        rx_pop = 0; tx_push = 0; set_uf = 0; set_of = 0; clr = 0; new_rxfl = 0; new_txfl = 0;

        if (m_rd_ack) begin
            m_rd_ack = 0; m_rd_rel = 1;
        end else if (m_rd_rel) begin
            m_rd_rel = up_rreq;
        end else if (up_rreq) begin
            m_rd_ack = 1;
            m_rdata  = '0;
            case (up_raddr)
                14'h0: if (rx_empty_p) set_uf = 1; else begin m_rdata = {24'd0, rxq[0]}; rx_pop = 1; end
                14'h8: begin m_rdata = status_p; clr = 1; end
                14'hC: m_rdata = {27'd0, m_txen, 4'd0};
                default: ;
            endcase
        end

        if (m_wr_ack) begin
            m_wr_ack = 0; m_wr_rel = 1;
        end else if (m_wr_rel) begin
            m_wr_rel = up_wreq;
        end else if (up_wreq) begin
            m_wr_ack = 1;
            case (up_waddr)
                14'h4: if (tx_full_p) set_of = 1; else tx_push = 1;
                14'hC: begin m_txen = up_wdata[4]; new_rxfl = up_wdata[0]; new_txfl = up_wdata[1]; end
                default: ;
            endcase
        end

        if (m_rxfl) rxq.delete();
        else begin
            if (rx_pop) void'(rxq.pop_front());
            if (s_push) rxq.push_back(s_axis_tdata);
        end
        if (m_txfl) txq.delete();
        else begin
            if (m_pop) void'(txq.pop_front());
            if (tx_push) txq.push_back(up_wdata[7:0]);
        end
        m_rxfl = new_rxfl;
        m_txfl = new_txfl;
        m_uf = (m_uf && !clr) || set_uf;
        m_of = (m_of && !clr) || set_of;
        m_rstn_q = 1;
    endtask

    task automatic check_all();
        chk("up_rack", {31'd0, up_rack}, {31'd0, m_rd_ack});
        chk("up_wack", {31'd0, up_wack}, {31'd0, m_wr_ack});
        chk("up_rdata", up_rdata, m_rdata);
        chk("s_axis_tready", {31'd0, s_axis_tready}, {31'd0, m_rstn_q && rxq.size() < DEPTH});
        chk("m_axis_tvalid", {31'd0, m_axis_tvalid}, {31'd0, m_txen && txq.size() > 0});
        chk("m_axis_tdata", {24'd0, m_axis_tdata}, (txq.size() > 0) ? {24'd0, txq[0]} : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic up_read(input logic [13:0] addr, input int hold, output logic [31:0] data);
        int acks;
        acks = 0;
        data = 32'hDEADBEEF;
        up_raddr = addr;
        up_rreq  = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (up_rack) begin acks++; data = up_rdata; end
        end
        up_rreq = 1'b0;
        tick();
        chk("rack_count", acks, 1);
    endtask

    task automatic up_write(input logic [13:0] addr, input logic [31:0] data);
        int acks;
        acks = 0;
        up_waddr = addr;
        up_wdata = data;
        up_wreq  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (up_wack) acks++;
        end
        up_wreq = 1'b0;
        tick();
        chk("wack_count", acks, 1);
    endtask

    task automatic stream_in(input logic [7:0] b);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    logic [31:0] d;
    logic [7:0]  last_out;
    int          n_out;
    logic [13:0] addrs [6];

    initial begin
        addrs = '{14'h0, 14'h4, 14'h8, 14'hC, 14'h10, 14'h2};
        rstn = 1'b0; up_rreq = 1'b0; up_wreq = 1'b0; up_raddr = '0; up_waddr = '0;
        up_wdata = '0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        m_rdata = '0;

        repeat (3) tick();
        chk("reset_rack", {31'd0, up_rack}, 32'd0);
        chk("reset_tready", {31'd0, s_axis_tready}, 32'd0);
        rstn = 1'b1;
        tick();
        chk("tready_after_reset", {31'd0, s_axis_tready}, 32'd1);
        up_read(14'h8, 3, d); chk("status_after_reset", d, 32'h0000_0005);

        stream_in(8'h11); stream_in(8'h22); stream_in(8'h33);
        up_read(14'h0, 5, d); chk("rx_read_1", d, 32'h11);
        up_read(14'h0, 5, d); chk("rx_read_2", d, 32'h22);
        up_read(14'h0, 5, d); chk("rx_read_3", d, 32'h33);
        up_read(14'h8, 3, d); chk("status_rx_drained", d, 32'h0000_0005);

        up_read(14'h0, 3, d); chk("rx_underflow_data", d, 32'h0);
        up_read(14'h8, 3, d); chk("status_underflow", d, 32'h8000_0005);
        up_read(14'h8, 3, d); chk("status_cleared", d, 32'h0000_0005);

        for (int i = 0; i < DEPTH; i++) stream_in(8'(8'h80 + i));
        stream_in(8'hEE);
        chk("tready_full", {31'd0, s_axis_tready}, 32'd0);
        up_read(14'h8, 3, d); chk("status_rx_full", d, 32'h0000_1006);
        up_read(14'h0, 3, d); chk("rx_head_after_fill", d, 32'h80);
        up_write(14'hC, 32'h1);
        up_read(14'h8, 3, d); chk("status_rx_flushed", d, 32'h0000_0005);

        up_write(14'h4, 32'hA5); up_write(14'h4, 32'h5A);
        chk("tx_disabled_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        up_write(14'hC, 32'h10);
        for (int i = 0; i < 3; i++) begin
            chk("tx_hold_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("tx_hold_tdata", {24'd0, m_axis_tdata}, 32'hA5);
            tick();
        end
        m_axis_tready = 1'b1;
        tick(); chk("tx_second_byte", {24'd0, m_axis_tdata}, 32'h5A);
        tick(); chk("tx_drained_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        m_axis_tready = 1'b0;

        up_write(14'hC, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) up_write(14'h4, 32'(8'h40 + i));
        up_read(14'h8, 3, d); chk("status_tx_overflow", d, 32'h4000_0009);
        up_read(14'h8, 3, d); chk("status_tx_full", d, 32'h0000_0009);
        up_write(14'hC, 32'h10);
        m_axis_tready = 1'b1;
        n_out = 0; last_out = '0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (m_axis_tvalid) begin n_out++; last_out = m_axis_tdata; end
            tick();
        end
        m_axis_tready = 1'b0;
        chk("tx_out_count", n_out, DEPTH);
        chk("tx_last_out", {24'd0, last_out}, 32'h4F);

        up_write(14'h4, 32'h61); up_write(14'h4, 32'h62); up_write(14'h4, 32'h63);
        chk("tx_pending_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        up_write(14'hC, 32'h12);
        chk("tx_flushed_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        up_read(14'h8, 3, d); chk("status_tx_flushed", d, 32'h0000_0005);

        stream_in(8'h77);
        rstn = 1'b0; up_raddr = 14'h0; up_rreq = 1'b1;
        tick(); chk("reset_abort_rack0", {31'd0, up_rack}, 32'd0);
        tick(); chk("reset_abort_rack1", {31'd0, up_rack}, 32'd0);
        rstn = 1'b1; up_rreq = 1'b0;
        tick();
        up_read(14'h8, 3, d); chk("status_after_abort", d, 32'h0000_0005);
        stream_in(8'h99);
        up_read(14'h0, 3, d); chk("rx_after_abort", d, 32'h99);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rstn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) up_rreq = ~up_rreq;
            if ($urandom_range(0, 3) == 0) up_wreq = ~up_wreq;
            if ($urandom_range(0, 7) == 0) up_raddr = addrs[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) up_waddr = addrs[$urandom_range(0, 5)];
            up_wdata = $urandom;
            if ($urandom_range(0, 7) != 0) up_wdata[1:0] = 2'b00;
            s_axis_tvalid = $urandom_range(0, 1) == 1;
            s_axis_tdata  = 8'($urandom);
            m_axis_tready = $urandom_range(0, 2) == 0;
            tick();
        end
        rstn = 1'b1; up_rreq = 1'b0; up_wreq = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
